// File: rtl/rate_div_pkg.sv
// Shared types and default reload constants for the rate divider family.
// Reload values assume a 50 MHz clock.
package rate_div_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int RL_FAST   = 0;
  localparam int RL_QTR_S  = 12499999;
  localparam int RL_HALF_S = 24999999;
  localparam int RL_1S     = 49999999;

endpackage

// File: rtl/tick_down_counter.sv
// Loadable down counter; load wins over decrement.
// Stops at zero so the owner decides when to reload.
module tick_down_counter #(
  parameter int CNT_W = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/multi_rate_pulse_gen.sv
// Run-time selectable periodic / one-shot pulse generator.
// Emits a one-cycle PULSE every R+1 enabled clocks.
module multi_rate_pulse_gen
  import rate_div_pkg::*;
#(
  parameter int CNT_W     = 28,
  parameter int NUM_RATES = 4,
  parameter int SEL_W     = 2,
  parameter int TICK_W    = 8,
  parameter logic [NUM_RATES*CNT_W-1:0] RELOADS = {
    CNT_W'(RL_1S),
    CNT_W'(RL_HALF_S),
    CNT_W'(RL_QTR_S),
    CNT_W'(RL_FAST)
  }
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic [SEL_W-1:0]  RATE,
  input  logic              MODE,
  input  logic              START,
  input  logic              STOP,
  input  logic              ENABLE,
  output logic              PULSE,
  output logic              BUSY,
  output logic [TICK_W-1:0] TICK_COUNT
);

  localparam int N_SEL = 2 ** SEL_W;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    rate_q, rate_d;
  logic                pulse_q, pulse_d;
  logic                busy_q, busy_d;
  logic [TICK_W-1:0]   tick_q, tick_d;

  logic                load;
  logic [CNT_W-1:0]    load_val;
  logic                cnt_en;
  logic                zero;

  // Out-of-range selects fold onto rate 0.
  logic [CNT_W-1:0] rl_tbl [N_SEL];

  for (genvar i = 0; i < N_SEL; i++) begin : g_rl
    if (i < NUM_RATES) begin : g_v
      assign rl_tbl[i] = RELOADS[i*CNT_W +: CNT_W];
    end else begin : g_d
      assign rl_tbl[i] = RELOADS[0 +: CNT_W];
    end
  end

  tick_down_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk      (CLOCK_50),
    .rst      (RESET),
    .load     (load),
    .load_val (load_val),
    .en       (cnt_en),
    .zero     (zero)
  );

  always_comb begin
    state_d  = state_q;
    rate_d   = rate_q;
    pulse_d  = 1'b0;
    tick_d   = tick_q;
    load     = 1'b0;
    load_val = rl_tbl[rate_q];
    cnt_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d  = ST_RUN;
          load     = 1'b1;
          load_val = rl_tbl[RATE];
          rate_d   = RATE;
          tick_d   = '0;
        end
      end
      ST_RUN: begin
        if (STOP) begin
          state_d  = ST_IDLE;
          load     = 1'b1;
          load_val = '0;
        end else if (START) begin
          load     = 1'b1;
          load_val = rl_tbl[RATE];
          rate_d   = RATE;
          tick_d   = '0;
        end else if (RATE != rate_q) begin
          load     = 1'b1;
          load_val = rl_tbl[RATE];
          rate_d   = RATE;
        end else if (ENABLE && zero) begin
          pulse_d  = 1'b1;
          tick_d   = tick_q + 1'b1;
          load     = 1'b1;
          if (MODE) begin
            state_d = ST_IDLE;
          end
        end else if (ENABLE) begin
          cnt_en   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      rate_q  <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      rate_q  <= rate_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      tick_q  <= tick_d;
    end
  end

  assign PULSE      = pulse_q;
  assign BUSY       = busy_q;
  assign TICK_COUNT = tick_q;

endmodule

// File: tb/tb_multi_rate_pulse_gen.sv
// Scoreboard bench for multi_rate_pulse_gen.
// Small configuration: R0=0, R1=2, R2=4, R3=9, 3-bit tick count.
module tb_multi_rate_pulse_gen;

  localparam int CNT_W  = 8;
  localparam int SEL_W  = 3;
  localparam int TICK_W = 3;

  logic              CLOCK_50 = 1'b0;
  logic              RESET;
  logic [SEL_W-1:0]  RATE;
  logic              MODE;
  logic              START;
  logic              STOP;
  logic              ENABLE;
  logic              PULSE;
  logic              BUSY;
  logic [TICK_W-1:0] TICK_COUNT;

  multi_rate_pulse_gen #(
    .CNT_W     (CNT_W),
    .NUM_RATES (4),
    .SEL_W     (SEL_W),
    .TICK_W    (TICK_W),
    .RELOADS   ({8'd9, 8'd4, 8'd2, 8'd0})
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET      (RESET),
    .RATE       (RATE),
    .MODE       (MODE),
    .START      (START),
    .STOP       (STOP),
    .ENABLE     (ENABLE),
    .PULSE      (PULSE),
    .BUSY       (BUSY),
    .TICK_COUNT (TICK_COUNT)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic              pulse;
    logic              busy;
    logic [TICK_W-1:0] tick;
  } exp_t;

  exp_t exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  // reference state
  bit m_run;
  int m_cnt;
  int m_rate;
  int m_tick;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rl(input int r);
    case (r)
      1:       return 2;
      2:       return 4;
      3:       return 9;
      default: return 0;
    endcase
  endfunction

  function automatic exp_t predict();
    exp_t e;
    e.pulse = 1'b0;
    if (RESET) begin
      m_run = 0; m_cnt = 0; m_rate = 0; m_tick = 0;
    end else if (!m_run) begin
      if (START) begin
        m_run = 1; m_cnt = rl(int'(RATE));
        m_rate = int'(RATE); m_tick = 0;
      end
    end else if (STOP) begin
      m_run = 0; m_cnt = 0;
    end else if (START) begin
      m_cnt = rl(int'(RATE)); m_rate = int'(RATE); m_tick = 0;
    end else if (int'(RATE) != m_rate) begin
      m_cnt = rl(int'(RATE)); m_rate = int'(RATE);
    end else if (ENABLE) begin
      if (m_cnt == 0) begin
        e.pulse = 1'b1;
        m_tick = (m_tick + 1) % (1 << TICK_W);
        m_cnt = rl(m_rate);
        if (MODE) m_run = 0;
      end else begin
        m_cnt--;
      end
    end
    e.busy = m_run;
    e.tick = TICK_W'(m_tick);
    return e;
  endfunction

  // one clock: predict, advance, compare away from the edge
  task automatic step();
    exp_t e;
    exp_q.push_back(predict());
    @(posedge CLOCK_50);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("pulse", int'(PULSE), int'(e.pulse));
      chk("busy", int'(BUSY), int'(e.busy));
      chk("tick", int'(TICK_COUNT), int'(e.tick));
    end
  endtask

  task automatic wait_pulse(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (PULSE) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (PULSE) n++;
    end
  endtask

  int n;

  initial begin
    RESET = 1'b1; RATE = '0; MODE = 1'b0;
    START = 1'b0; STOP = 1'b0; ENABLE = 1'b1;
    m_run = 0; m_cnt = 0; m_rate = 0; m_tick = 0;
    #1;
    step();
    step();
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_tick", int'(TICK_COUNT), 0);
    RESET = 1'b0;

    // periodic, R=2: pulses 3 cycles apart, tick wraps after 8
    RATE = 3'd1; START = 1'b1;
    step();
    START = 1'b0;
    for (int k = 0; k < 8; k++) begin
      wait_pulse(10, n);
      chk("period_r1", n, 3);
    end
    chk("tick_wrap", int'(TICK_COUNT), 0);

    // reset in the middle of a run
    step();
    RESET = 1'b1;
    step();
    step();
    chk("midrst_pulse", int'(PULSE), 0);
    chk("midrst_busy", int'(BUSY), 0);
    chk("midrst_tick", int'(TICK_COUNT), 0);
    RESET = 1'b0;
    step();

    // one-shot, R=4
    RATE = 3'd2; MODE = 1'b1; START = 1'b1;
    step();
    START = 1'b0;
    wait_pulse(10, n);
    chk("oneshot_lat", n, 5);
    chk("oneshot_busy", int'(BUSY), 0);
    count_pulses(20, n);
    chk("oneshot_quiet", n, 0);
    MODE = 1'b0;

    // rate switch mid-run at count=4
    RATE = 3'd3; START = 1'b1;
    step();
    START = 1'b0;
    for (int k = 0; k < 5; k++) step();
    RATE = 3'd1;
    step();
    chk("switch_edge", int'(PULSE), 0);
    wait_pulse(10, n);
    chk("switch_lat", n, 3);

    // ENABLE gap at count=1
    START = 1'b1;
    step();
    START = 1'b0;
    step();
    ENABLE = 1'b0;
    count_pulses(4, n);
    chk("en_hold", n, 0);
    ENABLE = 1'b1;
    wait_pulse(10, n);
    chk("en_resume", n, 2);

    // STOP beats START
    START = 1'b1; STOP = 1'b1;
    step();
    chk("stop_win_busy", int'(BUSY), 0);
    chk("stop_win_pulse", int'(PULSE), 0);
    STOP = 1'b0;

    // R=0 pulses every cycle
    RATE = 3'd0;
    step();
    START = 1'b0;
    count_pulses(6, n);
    chk("r0_every", n, 6);

    // out-of-range select acts as R0
    RATE = 3'd5;
    step();
    chk("rate5_switch", int'(PULSE), 0);
    count_pulses(5, n);
    chk("rate5_every", n, 5);
    STOP = 1'b1;
    step();
    STOP = 1'b0; START = 1'b1;
    step();
    START = 1'b0;
    count_pulses(5, n);
    chk("rate5_start", n, 5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
